// File: rtl/multi_clk_divider.sv
// ============================================================================
// multi_clk_divider: N-channel programmable clock/strobe divider  (rev 1.0)
// ============================================================================
`default_nettype none

module multi_clk_divider #(
  parameter int CHANNELS    = 3,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 50000000,
  parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                sync_restart,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic                cfg_mode,
  output logic [CHANNELS-1:0] sig_out,
  output logic [CHANNELS-1:0] tick
);

  localparam logic [CNT_W-1:0] DEF_DIV    = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CH_W:0]    NUM_CH     = (CH_W+1)'(CHANNELS);
  localparam logic             MODE_PULSE = 1'b1;

  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [CNT_W-1:0]    div_q [CHANNELS];
  logic [CNT_W-1:0]    div_d [CHANNELS];
  logic [CHANNELS-1:0] mode_q, mode_d;
  logic [CHANNELS-1:0] sig_q, sig_d;
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic                pend_q, pend_d;
  logic [CH_W-1:0]     pend_ch_q, pend_ch_d;
  logic [CNT_W-1:0]    pend_div_q, pend_div_d;
  logic                pend_mode_q, pend_mode_d;
  logic                accept;

  // Ready is simply "nothing staged", so it drops the cycle after a transfer
  // and rises the cycle after the staged config is applied.
  assign cfg_ready = ~pend_q;
  assign accept    = cfg_valid && cfg_ready && ({1'b0, cfg_ch} < NUM_CH);
  assign sig_out   = sig_q;
  assign tick      = tick_q;

  always_comb begin
    logic [CNT_W-1:0] d_eff;
    logic             wrap;
    logic             apply;
    d_eff       = ONE;
    wrap        = 1'b0;
    apply       = 1'b0;
    pend_d      = pend_q;
    pend_ch_d   = pend_ch_q;
    pend_div_d  = pend_div_q;
    pend_mode_d = pend_mode_q;
    mode_d      = mode_q;
    sig_d       = sig_q;
    tick_d      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      div_d[i] = div_q[i];
      d_eff    = (div_q[i] == '0) ? ONE : div_q[i];
      wrap     = ch_en[i] && (cnt_q[i] == d_eff - ONE);
      apply    = pend_q && (pend_ch_q == CH_W'(i)) &&
                 (sync_restart || wrap || !ch_en[i]);
      if (apply) begin
        div_d[i]  = pend_div_q;
        mode_d[i] = pend_mode_q;
        pend_d    = 1'b0;
      end
      if (sync_restart) begin
        cnt_d[i] = '0;
        sig_d[i] = 1'b0;
      end else if (apply) begin
        cnt_d[i]  = '0;
        tick_d[i] = wrap;
        if (pend_mode_q != mode_q[i])
          sig_d[i] = 1'b0;
        else if (mode_q[i] == MODE_PULSE)
          sig_d[i] = wrap;
        else
          sig_d[i] = sig_q[i] ^ wrap;
      end else if (ch_en[i]) begin
        cnt_d[i]  = wrap ? '0 : cnt_q[i] + ONE;
        tick_d[i] = wrap;
        sig_d[i]  = (mode_q[i] == MODE_PULSE) ? wrap : (sig_q[i] ^ wrap);
      end else begin
        sig_d[i] = (mode_q[i] == MODE_PULSE) ? 1'b0 : sig_q[i];
      end
    end
    if (accept) begin
      pend_d      = 1'b1;
      pend_ch_d   = cfg_ch;
      pend_div_d  = cfg_div;
      pend_mode_d = cfg_mode;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DEF_DIV;
      end
      mode_q      <= '0;
      sig_q       <= '0;
      tick_q      <= '0;
      pend_q      <= 1'b0;
      pend_ch_q   <= '0;
      pend_div_q  <= '0;
      pend_mode_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
      end
      mode_q      <= mode_d;
      sig_q       <= sig_d;
      tick_q      <= tick_d;
      pend_q      <= pend_d;
      pend_ch_q   <= pend_ch_d;
      pend_div_q  <= pend_div_d;
      pend_mode_q <= pend_mode_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_clk_divider.sv
// ============================================================================
// tb_multi_clk_divider: randomized self-checking bench with behavioural model
// ============================================================================
`default_nettype none

module tb_multi_clk_divider;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [2:0] ch_en;
  logic       sync_restart;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_mode;
  logic [2:0] sig_out;
  logic [2:0] tick;

  int n_checks;
  int n_pass;

  // Behavioural model: position inside the current period, divisor, mode.
  int m_pos  [3];
  int m_div  [3];
  bit m_mode [3];
  bit [2:0] m_sig;
  bit [2:0] m_tick;
  bit m_pend;
  int m_pch;
  int m_pdiv;
  bit m_pmode;

  multi_clk_divider #(.CHANNELS(3), .CNT_W(8), .DEFAULT_DIV(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ch_en(ch_en),
    .sync_restart(sync_restart), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .sig_out(sig_out), .tick(tick)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pos[i] = 0; m_div[i] = 4; m_mode[i] = 1'b0;
    end
    m_sig = '0; m_tick = '0; m_pend = 1'b0; m_pch = 0; m_pdiv = 0; m_pmode = 1'b0;
  endtask

  // Advance one clock: the model computes the next state from the inputs
  // present before the edge, then we land 1 time unit after the edge.
  task automatic step();
    int nc [3]; int nd [3]; bit nm [3];
    bit [2:0] ns; bit [2:0] nt; bit np;
    if (!sys_rst_n) begin
      @(posedge sys_clk);
      model_reset();
      #1;
      return;
    end
    np = m_pend; ns = m_sig; nt = '0;
    for (int i = 0; i < 3; i++) begin
      int d; bit at_end; bit tgt;
      d      = (m_div[i] == 0) ? 1 : m_div[i];
      at_end = ch_en[i] && (m_pos[i] + 1 == d);
      tgt    = m_pend && (m_pch == i);
      nc[i] = m_pos[i]; nd[i] = m_div[i]; nm[i] = m_mode[i];
      if (sync_restart) begin
        nc[i] = 0; ns[i] = 1'b0;
        if (tgt) begin nd[i] = m_pdiv; nm[i] = m_pmode; np = 1'b0; end
      end else if (tgt && (at_end || !ch_en[i])) begin
        nd[i] = m_pdiv; nm[i] = m_pmode; np = 1'b0; nc[i] = 0; nt[i] = at_end;
        if (m_pmode != m_mode[i]) ns[i] = 1'b0;
        else if (at_end) ns[i] = m_mode[i] ? 1'b1 : ~m_sig[i];
        else ns[i] = m_mode[i] ? 1'b0 : m_sig[i];
      end else if (ch_en[i]) begin
        nc[i] = at_end ? 0 : m_pos[i] + 1;
        nt[i] = at_end;
        ns[i] = m_mode[i] ? at_end : (m_sig[i] ^ at_end);
      end else begin
        ns[i] = m_mode[i] ? 1'b0 : m_sig[i];
      end
    end
    if (cfg_valid && !m_pend && cfg_ch < 2'd3) begin
      np = 1'b1; m_pch = int'(cfg_ch); m_pdiv = int'(cfg_div); m_pmode = cfg_mode;
    end
    @(posedge sys_clk);
    for (int i = 0; i < 3; i++) begin
      m_pos[i] = nc[i]; m_div[i] = nd[i]; m_mode[i] = nm[i];
    end
    m_sig = ns; m_tick = nt; m_pend = np;
    #1;
  endtask

  task automatic send_cfg(input int ch, input int dv, input bit md);
    cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_div = 8'(dv); cfg_mode = md;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; ch_en = '0; sync_restart = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
    model_reset();
    step(); step();
    n_checks++;
    if (sig_out !== 3'b000 || tick !== 3'b000 || cfg_ready !== 1'b1)
      $display("FAIL reset_state: sig=%b tick=%b rdy=%b, want 000 000 1", sig_out, tick, cfg_ready);
    else n_pass++;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_toggle_default();
    int ticks0, edges0; logic prev;
    ch_en = 3'b111; ticks0 = 0; edges0 = 0;
    for (int c = 0; c < 16; c++) begin
      prev = sig_out[0];
      step();
      if (tick[0] === 1'b1) ticks0++;
      if (sig_out[0] !== prev) edges0++;
      n_checks++;
      if (sig_out !== m_sig || tick !== m_tick)
        $display("FAIL toggle_default c%0d: sig=%b tick=%b, want %b %b", c, sig_out, tick, m_sig, m_tick);
      else n_pass++;
    end
    n_checks++;
    if (ticks0 != 4 || edges0 != 4)
      $display("FAIL toggle_rate: ticks=%0d edges=%0d, want 4 4", ticks0, edges0);
    else n_pass++;
  endtask

  task automatic test_cfg_pulse();
    int highs; int waited;
    step();
    send_cfg(1, 2, 1'b1);
    n_checks++;
    if (cfg_ready !== 1'b0) $display("FAIL cfg_pending_ready: got %b, want 0", cfg_ready);
    else n_pass++;
    waited = 0;
    while (cfg_ready !== 1'b1 && waited < 20) begin
      n_checks++;
      if (sig_out !== m_sig || cfg_ready !== !m_pend)
        $display("FAIL cfg_pulse_wait: sig=%b rdy=%b, want %b %b", sig_out, cfg_ready, m_sig, !m_pend);
      else n_pass++;
      step(); waited++;
    end
    n_checks++;
    if (waited >= 20 || cfg_ready !== !m_pend)
      $display("FAIL cfg_pulse_apply: rdy=%b after %0d cycles, want 1", cfg_ready, waited);
    else n_pass++;
    highs = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (sig_out[1] === 1'b1) highs++;
      n_checks++;
      if (sig_out !== m_sig || tick !== m_tick)
        $display("FAIL cfg_pulse c%0d: sig=%b tick=%b, want %b %b", c, sig_out, tick, m_sig, m_tick);
      else n_pass++;
    end
    n_checks++;
    if (highs != 4) $display("FAIL pulse_rate: highs=%0d, want 4", highs);
    else n_pass++;
  endtask

  task automatic test_div_zero_one();
    int same; int waited; logic prev;
    for (int k = 0; k < 2; k++) begin
      send_cfg(0, k, 1'b0);
      waited = 0;
      while (cfg_ready !== 1'b1 && waited < 20) begin step(); waited++; end
      n_checks++;
      if (waited >= 20 || sig_out !== m_sig)
        $display("FAIL div%0d_apply: sig=%b waited=%0d, want %b", k, sig_out, waited, m_sig);
      else n_pass++;
      same = 0;
      for (int c = 0; c < 6; c++) begin
        prev = sig_out[0];
        step();
        if (sig_out[0] === prev) same++;
      end
      n_checks++;
      if (same != 0 || sig_out !== m_sig)
        $display("FAIL div%0d_toggle: held %0d cycles sig=%b, want 0 %b", k, same, sig_out, m_sig);
      else n_pass++;
    end
  endtask

  task automatic test_disable();
    logic held;
    ch_en[2] = 1'b0;
    held = sig_out[2];
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++;
      if (sig_out[2] !== held || tick[2] !== 1'b0 || sig_out !== m_sig)
        $display("FAIL disable c%0d: sig=%b tick=%b, want %b tick2=0", c, sig_out, tick, m_sig);
      else n_pass++;
    end
    ch_en[2] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if (sig_out !== m_sig || tick !== m_tick)
        $display("FAIL reenable c%0d: sig=%b tick=%b, want %b %b", c, sig_out, tick, m_sig, m_tick);
      else n_pass++;
    end
  endtask

  task automatic test_restart();
    int waited;
    send_cfg(0, 7, 1'b0);
    waited = 0;
    while (cfg_ready !== 1'b1 && waited < 20) begin step(); waited++; end
    step();
    send_cfg(0, 3, 1'b1);
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    n_checks++;
    if (sig_out !== 3'b000 || tick !== 3'b000 || cfg_ready !== 1'b1 || m_pend)
      $display("FAIL restart: sig=%b tick=%b rdy=%b, want 000 000 1", sig_out, tick, cfg_ready);
    else n_pass++;
    for (int c = 0; c < 9; c++) begin
      step();
      n_checks++;
      if (sig_out !== m_sig || tick !== m_tick)
        $display("FAIL after_restart c%0d: sig=%b tick=%b, want %b %b", c, sig_out, tick, m_sig, m_tick);
      else n_pass++;
    end
  endtask

  task automatic test_discard_and_reset();
    int ticks2;
    send_cfg(3, 1, 1'b1);
    n_checks++;
    if (cfg_ready !== 1'b1 || sig_out !== m_sig)
      $display("FAIL discard: rdy=%b sig=%b, want 1 %b", cfg_ready, sig_out, m_sig);
    else n_pass++;
    send_cfg(2, 9, 1'b1);
    n_checks++;
    if (cfg_ready !== 1'b0) $display("FAIL pend_before_reset: rdy=%b, want 0", cfg_ready);
    else n_pass++;
    sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if (sig_out !== 3'b000 || tick !== 3'b000 || cfg_ready !== 1'b1)
      $display("FAIL async_reset: sig=%b tick=%b rdy=%b, want 000 000 1", sig_out, tick, cfg_ready);
    else n_pass++;
    step();
    sys_rst_n = 1'b1;
    ticks2 = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (tick[2] === 1'b1) ticks2++;
      n_checks++;
      if (sig_out !== m_sig || tick !== m_tick || cfg_ready !== 1'b1)
        $display("FAIL post_reset c%0d: sig=%b tick=%b, want %b %b", c, sig_out, tick, m_sig, m_tick);
      else n_pass++;
    end
    n_checks++;
    if (ticks2 != 2) $display("FAIL post_reset_div: ticks2=%0d, want 2", ticks2);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      ch_en        = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b111;
      sync_restart = ($urandom_range(0, 40) == 0);
      cfg_valid    = ($urandom_range(0, 5) == 0);
      cfg_ch       = 2'($urandom_range(0, 3));
      cfg_div      = 8'($urandom_range(0, 7));
      cfg_mode     = 1'($urandom);
      step();
      n_checks++;
      if (sig_out !== m_sig || tick !== m_tick || cfg_ready !== !m_pend)
        $display("FAIL random c%0d: sig=%b tick=%b rdy=%b, want %b %b %b",
                 c, sig_out, tick, cfg_ready, m_sig, m_tick, !m_pend);
      else n_pass++;
    end
    cfg_valid = 1'b0; sync_restart = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_toggle_default();
    test_cfg_pulse();
    test_div_zero_one();
    test_disable();
    test_restart();
    test_discard_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
